// File: rtl/queue_pkg.sv
// Shared constants for the burst queue source: FSM encodings and default widths.
package queue_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF  = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

endpackage

// File: rtl/queue_source.sv
// Burst generator feeding a queue enqueue port: takes a (start, step, count)
// command and emits count payloads start, start+step, ... with valid/ready flow control.
import queue_pkg::*;

module queue_source #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_start,
  input  logic [DATA_W-1:0] cmd_step,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic              enq,
  output logic [DATA_W-1:0] din,
  input  logic              enq_ready,
  output logic              done,
  output logic [CNT_W-1:0]  sent
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] din_q,   din_d;
  logic [DATA_W-1:0] step_q,  step_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  sent_q,  sent_d;

  // Next-state and datapath: din_q always holds start + sent*step for the pending beat.
  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    step_d  = step_q;
    count_d = count_q;
    sent_d  = sent_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          din_d   = cmd_start;
          step_d  = cmd_step;
          count_d = cmd_count;
          sent_d  = {CNT_W{1'b0}};
          state_d = (cmd_count != {CNT_W{1'b0}}) ? ST_SEND : ST_FINISH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (enq_ready) begin
          din_d   = din_q + step_q;
          sent_d  = sent_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = (sent_d == count_q) ? ST_FINISH : ST_SEND;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      din_q   <= {DATA_W{1'b0}};
      step_q  <= {DATA_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      sent_q  <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      step_q  <= step_d;
      count_q <= count_d;
      sent_q  <= sent_d;
    end
  end

  // Handshake outputs depend on state only, so enq_ready never reaches enq/din combinationally.
  assign cmd_ready = (state_q == ST_IDLE);
  assign enq       = (state_q == ST_SEND);
  assign done      = (state_q == ST_FINISH);
  assign din       = din_q;
  assign sent      = sent_q;

endmodule

// File: tb/tb_queue_source.sv
// Directed bench for queue_source with a payload scoreboard and a 2-entry queue model.
module tb_queue_source;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_start;
  logic [3:0] cmd_step;
  logic [4:0] cmd_count;
  logic       enq;
  logic [3:0] din;
  logic       enq_ready;
  logic       done;
  logic [4:0] sent;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;
  int dones    = 0;
  int mode     = 0;   // 0: always ready, 1: toggle, 2: 2-entry queue
  int fill     = 0;
  logic deq    = 1'b0;
  logic [3:0] sb[$];

  queue_source #(.DATA_W(4), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_step(cmd_step), .cmd_count(cmd_count),
    .enq(enq), .din(din), .enq_ready(enq_ready),
    .done(done), .sent(sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle, called at a falling edge: set ready, score a handshake, advance.
  task automatic step();
    logic [3:0] e;
    case (mode)
      1:       enq_ready = ~enq_ready;
      2:       enq_ready = (fill < 2);
      default: enq_ready = 1'b1;
    endcase
    if (enq && enq_ready) begin
      beats++;
      if (sb.size() == 0) begin
        chk("extra_beat", 32'(din), 32'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("din_beat", 32'(din), 32'(e));
      end
      if (mode == 2) fill++;
    end
    if (deq && fill > 0) fill--;
    if (done) dones++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] s, input logic [3:0] st, input logic [4:0] c);
    cmd_start = s; cmd_step = st; cmd_count = c; cmd_valid = 1'b1;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < int'(c); k++) sb.push_back(4'((int'(s) + k * int'(st)) & 15));
    beats = 0;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      step();
      cycles++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("enq_low_finish", 32'(enq), 32'd0);
  endtask

  task automatic after_done(input logic [4:0] exp_sent, input int exp_beats);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("sent_final", 32'(sent), 32'(exp_sent));
    chk("beat_count", 32'(beats), 32'(exp_beats));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    step();
    chk("sent_held", 32'(sent), 32'(exp_sent));
  endtask

  initial begin
    int cyc;
    reset = 1'b0; cmd_valid = 1'b0; cmd_start = 4'd0; cmd_step = 4'd0;
    cmd_count = 5'd0; enq_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_enq", 32'(enq), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sent", 32'(sent), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // start=1 step=1 count=2, always ready
    mode = 0;
    issue(4'd1, 4'd1, 5'd2);
    chk("first_enq_latency", 32'(enq), 32'd1);
    chk("first_din", 32'(din), 32'd1);
    wait_done(10, cyc);
    chk("b1_cycles", 32'(cyc), 32'd2);
    after_done(5'd2, 2);

    // count=3 into a 2-entry queue with no dequeue, then release one slot
    mode = 2; fill = 0;
    issue(4'd1, 4'd1, 5'd3);
    for (int i = 0; i < 6; i++) step();
    chk("stall_enq", 32'(enq), 32'd1);
    chk("stall_din", 32'(din), 32'd3);
    chk("stall_sent", 32'(sent), 32'd2);
    step();
    chk("stall_din_held", 32'(din), 32'd3);
    deq = 1'b1; step(); deq = 1'b0;
    wait_done(10, cyc);
    after_done(5'd3, 3);

    // wrap: E, 1, 4
    mode = 0;
    issue(4'hE, 4'd3, 5'd3);
    wait_done(10, cyc);
    after_done(5'd3, 3);

    // empty burst
    issue(4'd5, 4'd1, 5'd0);
    chk("empty_no_enq", 32'(enq), 32'd0);
    chk("empty_done_next", 32'(done), 32'd1);
    wait_done(3, cyc);
    chk("empty_cycles", 32'(cyc), 32'd0);
    after_done(5'd0, 0);

    // reset after first beat of a count=4 burst
    issue(4'd2, 4'd2, 5'd4);
    step();
    chk("pre_rst_sent", 32'(sent), 32'd1);
    dones = 0;
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_enq", 32'(enq), 32'd0);
    chk("rst_mid_din", 32'(din), 32'd0);
    chk("rst_mid_sent", 32'(sent), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    chk("no_done_after_rst", 32'(dones), 32'd0);
    issue(4'd9, 4'd1, 5'd1);
    chk("post_rst_enq", 32'(enq), 32'd1);
    wait_done(10, cyc);
    after_done(5'd1, 1);

    // ready toggling every cycle, count=5
    mode = 1; enq_ready = 1'b0;
    issue(4'd3, 4'd5, 5'd5);
    wait_done(30, cyc);
    after_done(5'd5, 5);

    // maximum count
    mode = 0;
    issue(4'd0, 4'd1, 5'd31);
    wait_done(60, cyc);
    chk("max_cycles", 32'(cyc), 32'd31);
    after_done(5'd31, 31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
